// File: rtl/seven_seg_scan_if.sv
// Display scanner signal bundle: BCD digits in, multiplexed
// common-anode segment/anode drive out.
interface seven_seg_scan_if;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_start;

    modport master (
        output digits_in, dp_in, blank_lz,
        input  seg_n, dp_n, an_n, frame_start
    );

    modport slave (
        input  digits_in, dp_in, blank_lz,
        output seg_n, dp_n, an_n, frame_start
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode 7-segment scanner with per-frame
// digit snapshot, anode guard interval and leading-zero blanking.
module seven_seg_scan #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic           clk,
    input  logic           reset_n,
    seven_seg_scan_if.slave bus
);
    localparam int CW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CW-1:0] LAST     = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] BLANK_AT = CW'(BLANK_TICKS);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   sh_dig;
    logic [3:0]    sh_dp;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    blank;
    logic [3:0]    dig;
    logic          dp_req;
    logic [6:0]    seg_dec;
    logic          lit;

    assign slot_end  = (cnt == LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    // Blanking chains down from the leftmost digit on snapshot values
    always_comb begin
        blank    = 4'b0000;
        blank[3] = bus.blank_lz && (sh_dig[15:12] == 4'h0);
        blank[2] = blank[3] && (sh_dig[11:8] == 4'h0);
        blank[1] = blank[2] && (sh_dig[7:4] == 4'h0);
    end

    always_comb begin
        dig    = 4'h0;
        dp_req = 1'b0;
        unique case (idx)
            2'd0: begin dig = sh_dig[3:0];   dp_req = sh_dp[0]; end
            2'd1: begin dig = sh_dig[7:4];   dp_req = sh_dp[1]; end
            2'd2: begin dig = sh_dig[11:8];  dp_req = sh_dp[2]; end
            2'd3: begin dig = sh_dig[15:12]; dp_req = sh_dp[3]; end
        endcase
    end

    always_comb begin
        seg_dec = 7'h3F;
        unique case (dig)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;
        endcase
    end

    assign lit = (cnt >= BLANK_AT) && !blank[idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            idx    <= 2'd0;
            sh_dig <= 16'h0000;
            sh_dp  <= 4'h0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_end) begin
                sh_dig <= bus.digits_in;
                sh_dp  <= bus.dp_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.seg_n       <= 7'h7F;
            bus.dp_n        <= 1'b1;
            bus.an_n        <= 4'hF;
            bus.frame_start <= 1'b0;
        end else begin
            bus.seg_n       <= lit ? seg_dec : 7'h7F;
            bus.dp_n        <= lit ? ~dp_req : 1'b1;
            bus.an_n        <= lit ? ~(4'b0001 << idx) : 4'hF;
            bus.frame_start <= frame_end;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed steps plus random inputs,
// every cycle compared against a time-based display model.
module tb_seven_seg_scan;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_if bus();

    seven_seg_scan #(
        .DIGIT_TICKS(8),
        .BLANK_TICKS(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    int t = 0;
    logic [15:0] sh_d = 16'h0;
    logic [3:0]  sh_p = 4'h0;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fs;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model state is elapsed cycles since reset release: 8 per slot,
    // 4 slots per frame, snapshot at the last cycle of each frame.
    task automatic step();
        int phase, slot, d;
        logic lead, blanked;
        @(posedge clk);
        phase = t % 8;
        slot  = (t / 8) % 4;
        d     = int'(sh_d[slot*4 +: 4]);
        lead  = bus.blank_lz;
        blanked = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            if (lead && sh_d[i*4 +: 4] == 4'h0) begin
                if (i == slot) blanked = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
        if (phase >= 2 && !blanked) begin
            e_seg = (d > 9) ? 7'h3F : seg_tab[d];
            e_an  = 4'hF & ~(4'b0001 << slot);
            e_dp  = ~sh_p[slot];
        end else begin
            e_seg = 7'h7F;
            e_an  = 4'hF;
            e_dp  = 1'b1;
        end
        e_fs = (t % 32 == 31);
        if (e_fs) begin
            sh_d = bus.digits_in;
            sh_p = bus.dp_in;
        end
        t++;
        #1;
        chk("seg_n", 16'(bus.seg_n), 16'(e_seg));
        chk("an_n", 16'(bus.an_n), 16'(e_an));
        chk("dp_n", 16'(bus.dp_n), 16'(e_dp));
        chk("frame_start", 16'(bus.frame_start), 16'(e_fs));
        chk("one_anode", 16'($countones(~bus.an_n) <= 1), 16'd1);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg"}, 16'(bus.seg_n), 16'h7F);
        chk({tag, "_an"}, 16'(bus.an_n), 16'hF);
        chk({tag, "_dp"}, 16'(bus.dp_n), 16'h1);
        chk({tag, "_fs"}, 16'(bus.frame_start), 16'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_reset_vals("rst_async");
        repeat (2) @(posedge clk);
        #1 chk_reset_vals("rst_hold");
        reset_n = 1'b1;
        t = 0;
        sh_d = 16'h0;
        sh_p = 4'h0;
    endtask

    initial begin
        int fs_cnt;
        bus.digits_in = 16'h1234;
        bus.dp_in = 4'h0;
        bus.blank_lz = 1'b0;
        do_reset();

        // Scan order in frame 2
        run(36);
        chk("scan_d0_an", 16'(bus.an_n), 16'hE);
        chk("scan_d0_seg", 16'(bus.seg_n), 16'h19);
        run(8);
        chk("scan_d1_an", 16'(bus.an_n), 16'hD);
        chk("scan_d1_seg", 16'(bus.seg_n), 16'h30);
        run(8);
        chk("scan_d2_an", 16'(bus.an_n), 16'hB);
        chk("scan_d2_seg", 16'(bus.seg_n), 16'h24);
        run(8);
        chk("scan_d3_an", 16'(bus.an_n), 16'h7);
        chk("scan_d3_seg", 16'(bus.seg_n), 16'h79);

        // Snapshot: change input while slot 1 is scanning
        bus.digits_in = 16'h0959;
        run(12);
        while (t % 32 != 8) step();
        bus.digits_in = 16'h1000;
        fs_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (bus.frame_start) fs_cnt++;
            if (t % 32 == 27)
                chk("tear_d3_old", 16'(bus.seg_n), 16'h40);
        end
        chk("fs_per_frame", 16'(fs_cnt), 16'd1);
        while (t % 32 != 28) step();
        chk("tear_d3_new", 16'(bus.seg_n), 16'h79);

        // Leading-zero blanking
        bus.digits_in = 16'h0005;
        bus.blank_lz = 1'b1;
        run(64);
        for (int i = 0; i < 32; i++) begin
            step();
            chk("lz_only_d0", 16'(bus.an_n == 4'hF || bus.an_n == 4'hE), 16'd1);
        end
        bus.digits_in = 16'h0105;
        run(64);
        bus.digits_in = 16'h0000;
        run(64);

        // Invalid BCD and decimal point
        bus.digits_in = 16'hA000;
        bus.dp_in = 4'b0100;
        bus.blank_lz = 1'b0;
        run(64);

        // Random inputs, changed at arbitrary cycles
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < 4; k++)
                    bus.digits_in[k*4 +: 4] = ($urandom_range(0, 2) == 0) ?
                        4'h0 : 4'($urandom_range(0, 15));
                bus.dp_in = 4'($urandom);
                bus.blank_lz = 1'($urandom);
            end
            step();
        end

        // Reset in the middle of a slot
        while (t % 8 != 4) step();
        do_reset();
        run(80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Consumer of the clock's BCD digit counters. It multiplexes four BCD digits onto the Mimas V2 4-digit common-anode 7-segment display. Digits are snapshotted once per scan frame, so a counter rollover mid-frame never tears the display. Each digit slot starts with an anode-off guard interval to suppress ghosting. Sits between the decade counters (HH:MM or MM:SS) and the display pins.

Parameters:
DIGIT_TICKS, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= 2
BLANK_TICKS, 1000, cycles at the start of each slot with all anodes off; must be < DIGIT_TICKS

Ports:
clk  input  1  system clock (100 MHz)
reset_n  input  1  asynchronous active-low reset
digits_in  input  16  four BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3 (leftmost)
dp_in  input  4  decimal point request per digit, 1=lit; bit i belongs to digit i
blank_lz  input  1  1=leading-zero blanking enabled
seg_n  output  7  segments {g,f,e,d,c,b,a}, active low
dp_n  output  1  decimal point, active low
an_n  output  4  digit anodes, active low; bit i drives digit i
frame_start  output  1  one-cycle pulse when a new frame begins and the snapshot has been taken

Behaviour:
- Reset (reset_n=0, asynchronous) clears all state:
  - prescaler cnt=0, slot idx=0, shadow digits=0, shadow dp=0.
  - seg_n=7'h7F, dp_n=1, an_n=4'hF, frame_start=0.
- Prescaler:
  - cnt counts 0..DIGIT_TICKS-1.
  - At cnt==DIGIT_TICKS-1: cnt<=0 and idx<=idx+1, wrapping 3->0.
- Frame boundary = the cycle with cnt==DIGIT_TICKS-1 and idx==3. In that cycle:
  - shadow digits<=digits_in, shadow dp<=dp_in.
  - frame_start<=1 for exactly one cycle, coincident with idx becoming 0.
- digits_in and dp_in are sampled only at frame boundaries; changes at any other time have no effect until the next boundary.
- First snapshot is taken at the end of the first frame after reset. Until then, shadows are 0.
- All outputs are registered from the current cnt/idx/shadow state, so they lag cnt/idx by one clock.
- Anodes:
  - an_n[idx]=0 only when cnt>=BLANK_TICKS and the digit is not blanked.
  - All other an_n bits =1.
  - At most one an_n bit is low in any cycle.
- Segment decode (active low) for digit d=shadow[idx]:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - 10..15 (invalid BCD) = 7'h3F (dash, g only) as a visible error indicator.
- seg_n=7'h7F whenever the slot is in its guard interval or blanked. dp_n=~shadow_dp[idx] during the lit interval, else 1.
- Leading-zero blanking (blank_lz=1), evaluated on shadow values:
  - digit3 is blanked if 0.
  - digit2 is blanked if 0 and digit3 is blanked.
  - digit1 is blanked if 0 and digit2 is blanked.
  - digit0 is never blanked.
  - A blanked digit drives an_n bit=1, seg_n=7'h7F, dp_n=1, even if its dp is requested.
- blank_lz is sampled live, not snapshotted.
- Reset mid-slot: outputs go to reset values immediately; scanning restarts at idx=0, cnt=0 on release.

Test Plan:
- Bench parameters: DIGIT_TICKS=8, BLANK_TICKS=2 for all cases.
- Reset: hold reset_n=0 with digits_in=16'h1234 -> seg_n=7'h7F, an_n=4'hF, dp_n=1, frame_start=0; assert mid-slot -> outputs clear without waiting for clk.
- Scan order: digits_in=16'h1234, blank_lz=0, run 2 frames -> in frame 2, per slot: 2 cycles an_n=4'hF, then 6 cycles of:
  - digit0: an_n=4'hE, seg_n=7'h19
  - digit1: an_n=4'hD, seg_n=7'h30
  - digit2: an_n=4'hB, seg_n=7'h24
  - digit3: an_n=4'h7, seg_n=7'h79
- Snapshot/tearing: change digits_in from 16'h0959 to 16'h1000 while idx=1 -> the rest of that frame still shows 9,5,9,0; the new value appears only after the next frame_start; frame_start is high exactly 1 cycle every 32.
- Leading-zero blanking: digits_in=16'h0005, blank_lz=1 -> only an_n=4'hE is ever driven low (seg_n=7'h12). digits_in=16'h0105 -> digit3 blank, digit2 shows 7'h79, digit1 shows 7'h40. digits_in=16'h0000 -> digit0 shows 7'h40.
- Invalid BCD and DP: digits_in=16'hA000, dp_in=4'b0100, blank_lz=0 -> digit3 seg_n=7'h3F; dp_n=0 only during digit2's lit interval.
